seq_divider: RTL

Iterative restoring divider for the 8-bit computer datapath. It is the sequential counterpart that consumes trial-subtraction results: one subtract-and-compare step per clock. It sits beside the combinational ALU and is driven by the control unit with a start/done handshake, so divide instructions can stall the sequencer until the result is ready.

---
 rtl/seq_divider_pkg.sv | 23 ++
 rtl/seq_divider_step.sv | 35 +++
 rtl/seq_divider.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encodings, default geometry and the divide-by-zero quotient pattern.
package seq_divider_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } div_state_e;

   // Quotient reported for a zero divisor (all ones at any width)
   function automatic logic [63:0] div_zero_q(input int width);
      logic [63:0] v;
      v = 64'd0;
      for (int i = 0; i < width; i++) begin
         v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/seq_divider_step.sv
// div_step: one combinational restoring-division iteration
// (shift {A,Q} left, trial-subtract D, restore on borrow).
module div_step
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] a_next,
   output logic [WIDTH-1:0] q_next,
   output logic             borrow
);

   logic [WIDTH-1:0] a_sh_s;
   logic [WIDTH-1:0] q_sh_s;
   logic [WIDTH:0]   trial_s;

   // Trial subtraction; a bit shifted out of A means A_shifted >= 2^WIDTH > D
   always_comb begin
      a_sh_s  = {a[WIDTH-2:0], q[WIDTH-1]};
      q_sh_s  = {q[WIDTH-2:0], 1'b0};
      trial_s = {1'b0, a_sh_s} - {1'b0, d};
      borrow  = trial_s[WIDTH] & ~a[WIDTH-1];
      if (borrow) begin
         a_next = a_sh_s;
         q_next = q_sh_s;
      end else begin
         a_next = trial_s[WIDTH-1:0];
         q_next = q_sh_s | {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider with start/done handshake.
// Optional two's-complement operands via macro SEQ_DIVIDER_SIGNED_EN.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam logic [63:0]      DZQ_FULL   = div_zero_q(WIDTH);
   localparam logic [WIDTH-1:0] DIV_ZERO_Q = DZQ_FULL[WIDTH-1:0];
   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(WIDTH - 1);

   div_state_e       state_r, state_s;
   logic [WIDTH-1:0] a_r, q_r, d_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] a_nxt_s, q_nxt_s;
   logic             borrow_s;
   logic             load_s, zero_s, finish_s;
   logic [WIDTH-1:0] dd_core_s, dv_core_s;
   logic [WIDTH-1:0] q_fin_s, r_fin_s;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic neg_q_r, neg_r_r;

   // Magnitudes feed the unsigned core; signs are restored on the final edge
   always_comb begin
      dd_core_s = dividend[WIDTH-1] ? (-dividend) : dividend;
      dv_core_s = divisor[WIDTH-1]  ? (-divisor)  : divisor;
      q_fin_s   = neg_q_r ? (-q_nxt_s) : q_nxt_s;
      r_fin_s   = neg_r_r ? (-a_nxt_s) : a_nxt_s;
   end
`else
   // Unsigned operands pass straight through
   always_comb begin
      dd_core_s = dividend;
      dv_core_s = divisor;
      q_fin_s   = q_nxt_s;
      r_fin_s   = a_nxt_s;
   end
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .a      (a_r),
      .q      (q_r),
      .d      (d_r),
      .a_next (a_nxt_s),
      .q_next (q_nxt_s),
      .borrow (borrow_s)
   );

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and step control
   always_comb begin
      state_s  = state_r;
      load_s   = 1'b0;
      zero_s   = 1'b0;
      finish_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (divisor == {WIDTH{1'b0}}) begin
                  zero_s = 1'b1;
               end else begin
                  load_s  = 1'b1;
                  state_s = ST_RUN;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cnt_r == LAST_CNT) begin
               finish_s = 1'b1;
               state_s  = ST_IDLE;
            end else begin
               state_s = ST_RUN;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Datapath, counter and registered handshake/result outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_r         <= {WIDTH{1'b0}};
         q_r         <= {WIDTH{1'b0}};
         d_r         <= {WIDTH{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= {WIDTH{1'b0}};
         remainder   <= {WIDTH{1'b0}};
         div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         neg_q_r     <= 1'b0;
         neg_r_r     <= 1'b0;
`endif
      end else begin
         busy <= (state_s == ST_RUN);
         done <= 1'b0;
         if (load_s) begin
            a_r   <= {WIDTH{1'b0}};
            q_r   <= dd_core_s;
            d_r   <= dv_core_s;
            cnt_r <= {CNT_W{1'b0}};
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_r <= dividend[WIDTH-1];
`endif
         end else if (state_r == ST_RUN) begin
            a_r   <= a_nxt_s;
            q_r   <= q_nxt_s;
            cnt_r <= cnt_r + CNT_W'(1);
         end
         if (zero_s) begin
            quotient    <= DIV_ZERO_Q;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
         end else if (finish_s) begin
            quotient    <= q_fin_s;
            remainder   <= r_fin_s;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
         end
      end
   end

endmodule
